// File: rtl/pipe_register_if.sv
// Handshake bundle for pipe_register: input side, output side and occupancy.
// The block sits on the slave modport; whatever drives it uses master.
interface pipe_register_if #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output in_valid,
        output data_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_out,
        input  occupancy
    );

    modport slave (
        input  in_valid,
        input  data_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_out,
        output occupancy
    );
endinterface

// File: rtl/pipe_register.sv
// Elastic pipeline register: STAGES stages of WIDTH bits, each with its own
// valid bit, linked by a combinational valid/ready chain so bubbles collapse
// and back-pressure reaches the input. Tracks the number of valid stages.
//
// Optional build macro PIPE_REGISTER_ZERO_EN: every stage that ends up
// invalid after an edge also clears its data, so data_out reads 0 whenever
// out_valid is low. Without it invalid stages keep stale data.
//
// The bus interface instance must be parameterised with the same WIDTH and
// STAGES as this module.
module pipe_register #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             ctrl_reset,
    input  logic             ctrl_flush,
    pipe_register_if.slave   bus
);
    localparam int OCC_W = $clog2(STAGES + 1);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    logic [STAGES-1:0] stageValid_q;
    logic [STAGES-1:0] stageValid_d;
    logic [WIDTH-1:0]  stageData_q [STAGES];
    logic [WIDTH-1:0]  stageData_d [STAGES];
    logic [OCC_W-1:0]  occCount_q;
    logic [OCC_W-1:0]  occCount_d;

    logic [STAGES-1:0] advance;
    logic              inReady;
    logic              inXfer;
    logic              outXfer;

    // Ready chain: a stage may advance if it, or any stage ahead of it, is empty, or the sink is taking the last word.
    always_comb begin : readyChain
        logic allFullAhead;
        allFullAhead = 1'b1;
        advance      = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            allFullAhead = allFullAhead & stageValid_q[k];
            advance[k]   = bus.out_ready | ~allFullAhead;
        end
    end

    assign inReady = advance[0] & ~ctrl_flush;
    assign inXfer  = bus.in_valid & inReady;
    assign outXfer = stageValid_q[STAGES-1] & bus.out_ready;

    // Next-state for the stage chain: shift where allowed, hold elsewhere, flush wins over everything.
    always_comb begin
        stageValid_d = stageValid_q;
        for (int k = 0; k < STAGES; k++) begin
            stageData_d[k] = stageData_q[k];
        end

        if (advance[0]) begin
            stageValid_d[0] = inXfer;
            stageData_d[0]  = bus.data_in;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (advance[k]) begin
                stageValid_d[k] = stageValid_q[k-1];
                stageData_d[k]  = stageData_q[k-1];
            end
        end

        if (ctrl_flush) begin
            stageValid_d = '0;
        end

`ifdef PIPE_REGISTER_ZERO_EN
        for (int k = 0; k < STAGES; k++) begin
            if (!stageValid_d[k]) begin
                stageData_d[k] = '0;
            end
        end
`endif
    end

    // Occupancy moves only when exactly one side transfers; flush empties it.
    always_comb begin
        occCount_d = occCount_q;
        if (ctrl_flush) begin
            occCount_d = '0;
        end else if (inXfer && !outXfer) begin
            occCount_d = occCount_q + OCC_ONE;
        end else if (outXfer && !inXfer) begin
            occCount_d = occCount_q - OCC_ONE;
        end
    end

    // State registers with asynchronous active-low clear of valids, data and count.
    always_ff @(posedge clk or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            stageValid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stageData_q[k] <= '0;
            end
            occCount_q <= '0;
        end else begin
            stageValid_q <= stageValid_d;
            for (int k = 0; k < STAGES; k++) begin
                stageData_q[k] <= stageData_d[k];
            end
            occCount_q <= occCount_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = stageValid_q[STAGES-1];
    assign bus.data_out  = stageData_q[STAGES-1];
    assign bus.occupancy = occCount_q;
endmodule

// File: tb/tb_pipe_register.sv
// Testbench for pipe_register: a 2-stage and a 3-stage instance share the
// same input stimulus. Each is compared every cycle against a word-position
// reference model; the 2-stage one is also checked against a hand-built
// vector table, and a few multi-cycle corner cases are written out by hand.
module tb_pipe_register;
    localparam int WIDTH = 64;

    logic             clk;
    logic             ctrlReset;
    logic             ctrlFlush;
    logic             inValid;
    logic             outReady;
    logic [WIDTH-1:0] dataIn;

    int checks;
    int errors;

    pipe_register_if #(.WIDTH(WIDTH), .STAGES(2)) bus2 ();
    pipe_register_if #(.WIDTH(WIDTH), .STAGES(3)) bus3 ();

    assign bus2.in_valid  = inValid;
    assign bus2.data_in   = dataIn;
    assign bus2.out_ready = outReady;
    assign bus3.in_valid  = inValid;
    assign bus3.data_in   = dataIn;
    assign bus3.out_ready = outReady;

    pipe_register #(.WIDTH(WIDTH), .STAGES(2)) dut2 (
        .clk        (clk),
        .ctrl_reset (ctrlReset),
        .ctrl_flush (ctrlFlush),
        .bus        (bus2.slave)
    );

    pipe_register #(.WIDTH(WIDTH), .STAGES(3)) dut3 (
        .clk        (clk),
        .ctrl_reset (ctrlReset),
        .ctrl_flush (ctrlFlush),
        .bus        (bus3.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    typedef struct {
        logic        inV;
        logic [63:0] din;
        logic        oRdy;
        logic        flush;
        logic        eOv;
        logic [63:0] eData;
        int          eOcc;
        logic        eIr;
    } vecT;

    vecT vecs[$];

    // Reference model: words in flight, oldest first, each with its stage position.
    logic [63:0] mData  [2][4];
    int          mPos   [2][4];
    int          mCnt   [2];
    int          mDepth [2];

    task automatic addVec(input logic inV, input logic [63:0] din, input logic oRdy,
                          input logic flush, input logic eOv, input logic [63:0] eData,
                          input int eOcc, input logic eIr);
        vecT v;
        v.inV = inV; v.din = din; v.oRdy = oRdy; v.flush = flush;
        v.eOv = eOv; v.eData = eData; v.eOcc = eOcc; v.eIr = eIr;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sampleDut(input int id, output logic ov, output logic [63:0] d,
                             output int occ, output logic ir);
        if (id == 0) begin
            ov = bus2.out_valid; d = bus2.data_out; occ = int'(bus2.occupancy); ir = bus2.in_ready;
        end else begin
            ov = bus3.out_valid; d = bus3.data_out; occ = int'(bus3.occupancy); ir = bus3.in_ready;
        end
    endtask

    task automatic resetModels();
        mCnt[0] = 0;
        mCnt[1] = 0;
    endtask

    // Compare one instance against the model's view of the current cycle.
    task automatic checkModel(input int id);
        int          depth;
        int          cnt;
        logic        expOv;
        logic        expIr;
        logic        ov;
        logic        ir;
        logic [63:0] d;
        int          occ;
        string       tag;
        depth = mDepth[id];
        cnt   = mCnt[id];
        expOv = (cnt > 0) && (mPos[id][0] == depth - 1);
        expIr = !ctrlFlush && (outReady || cnt < depth);
        tag   = $sformatf("model s%0d", depth);
        sampleDut(id, ov, d, occ, ir);
        checkOutput({tag, " outValid"}, 64'(ov), 64'(expOv));
        checkOutput({tag, " occupancy"}, 64'(occ), 64'(cnt));
        checkOutput({tag, " inReady"}, 64'(ir), 64'(expIr));
        if (expOv) begin
            checkOutput({tag, " dataOut"}, d, mData[id][0]);
        end
`ifdef PIPE_REGISTER_ZERO_EN
        else begin
            checkOutput({tag, " dataOut zero"}, d, 64'h0);
        end
`endif
    endtask

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic modelStep(input int id);
        int   depth;
        int   cnt;
        logic ov;
        logic ir;
        logic inX;
        logic outX;
        depth = mDepth[id];
        cnt   = mCnt[id];
        ov    = (cnt > 0) && (mPos[id][0] == depth - 1);
        ir    = !ctrlFlush && (outReady || cnt < depth);
        inX   = inValid && ir;
        outX  = ov && outReady;
        if (ctrlFlush) begin
            mCnt[id] = 0;
            return;
        end
        for (int i = 0; i < cnt; i++) begin
            if (mPos[id][i] < depth - 1 && (outReady || i < depth - 1 - mPos[id][i])) begin
                mPos[id][i] = mPos[id][i] + 1;
            end
        end
        if (outX) begin
            for (int i = 0; i < cnt - 1; i++) begin
                mData[id][i] = mData[id][i+1];
                mPos[id][i]  = mPos[id][i+1];
            end
            cnt--;
        end
        if (inX) begin
            mData[id][cnt] = dataIn;
            mPos[id][cnt]  = 0;
            cnt++;
        end
        mCnt[id] = cnt;
    endtask

    task automatic driveInputs(input logic inV, input logic [63:0] din, input logic oRdy, input logic fl);
        inValid   = inV;
        dataIn    = din;
        outReady  = oRdy;
        ctrlFlush = fl;
        #1;
    endtask

    task automatic advanceCycle();
        modelStep(0);
        modelStep(1);
        @(negedge clk);
    endtask

    // One full cycle: drive, model-check both instances, clock.
    task automatic applyStimulus(input logic inV, input logic [63:0] din, input logic oRdy, input logic fl);
        driveInputs(inV, din, oRdy, fl);
        checkModel(0);
        checkModel(1);
        advanceCycle();
    endtask

    initial begin
        logic        ov;
        logic        ir;
        logic [63:0] d;
        int          occ;

        checks = 0;
        errors = 0;
        mDepth[0] = 2;
        mDepth[1] = 3;
        resetModels();

        ctrlReset = 1'b0;
        ctrlFlush = 1'b0;
        inValid   = 1'b0;
        outReady  = 1'b0;
        dataIn    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        for (int id = 0; id < 2; id++) begin
            sampleDut(id, ov, d, occ, ir);
            checkOutput("reset outValid", 64'(ov), 64'h0);
            checkOutput("reset dataOut", d, 64'h0);
            checkOutput("reset occupancy", 64'(occ), 64'h0);
            checkOutput("reset inReady", 64'(ir), 64'h1);
        end
        ctrlFlush = 1'b1;
        #1;
        checkOutput("reset inReady with flush", 64'(bus2.in_ready), 64'h0);
        ctrlFlush = 1'b0;
        ctrlReset = 1'b1;
        @(negedge clk);

        // Directed table for the 2-stage instance: streaming, fill under stall, flush
        addVec(1'b1, 64'h1,    1'b1, 1'b0, 1'b0, 64'h0,    0, 1'b1);
        addVec(1'b1, 64'h2,    1'b1, 1'b0, 1'b0, 64'h0,    1, 1'b1);
        addVec(1'b1, 64'h3,    1'b1, 1'b0, 1'b1, 64'h1,    2, 1'b1);
        addVec(1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 64'h2,    2, 1'b1);
        addVec(1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 64'h3,    1, 1'b1);
        addVec(1'b1, 64'hA,    1'b0, 1'b0, 1'b0, 64'h0,    0, 1'b1);
        addVec(1'b1, 64'hB,    1'b0, 1'b0, 1'b0, 64'h0,    1, 1'b1);
        addVec(1'b1, 64'hC,    1'b0, 1'b0, 1'b1, 64'hA,    2, 1'b0);
        addVec(1'b1, 64'hC,    1'b1, 1'b0, 1'b1, 64'hA,    2, 1'b1);
        addVec(1'b0, 64'h0,    1'b0, 1'b0, 1'b1, 64'hB,    2, 1'b0);
        addVec(1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 64'hB,    2, 1'b1);
        addVec(1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 64'hC,    1, 1'b1);
        addVec(1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b0, 64'h0,    0, 1'b1);
        addVec(1'b1, 64'hBEEF, 1'b0, 1'b0, 1'b0, 64'h0,    1, 1'b1);
        addVec(1'b1, 64'h1234, 1'b0, 1'b1, 1'b1, 64'hDEAD, 2, 1'b0);
        addVec(1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0,    0, 1'b1);
        addVec(1'b1, 64'h55,   1'b0, 1'b1, 1'b0, 64'h0,    0, 1'b0);
        addVec(1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0,    0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            driveInputs(vecs[i].inV, vecs[i].din, vecs[i].oRdy, vecs[i].flush);
            checkOutput($sformatf("vec%0d outValid", i), 64'(bus2.out_valid), 64'(vecs[i].eOv));
            checkOutput($sformatf("vec%0d occupancy", i), 64'(bus2.occupancy), 64'(vecs[i].eOcc));
            checkOutput($sformatf("vec%0d inReady", i), 64'(bus2.in_ready), 64'(vecs[i].eIr));
            if (vecs[i].eOv) begin
                checkOutput($sformatf("vec%0d dataOut", i), bus2.data_out, vecs[i].eData);
            end
`ifdef PIPE_REGISTER_ZERO_EN
            else begin
                checkOutput($sformatf("vec%0d dataOut zero", i), bus2.data_out, 64'h0);
            end
`endif
            checkModel(0);
            checkModel(1);
            advanceCycle();
        end

        // Bubble collapse in the 3-stage instance under a stalled sink
        applyStimulus(1'b1, 64'h5, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h6, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        driveInputs(1'b0, 64'h0, 1'b0, 1'b0);
        checkOutput("bubble s3 outValid", 64'(bus3.out_valid), 64'h1);
        checkOutput("bubble s3 dataOut", bus3.data_out, 64'h5);
        checkOutput("bubble s3 occupancy", 64'(bus3.occupancy), 64'h2);
        checkOutput("bubble s3 inReady", 64'(bus3.in_ready), 64'h1);
        checkModel(0);
        checkModel(1);
        advanceCycle();
        repeat (4) applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges with two words in flight
        applyStimulus(1'b1, 64'h11, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h22, 1'b0, 1'b0);
        checkOutput("pre-reset s2 occupancy", 64'(bus2.occupancy), 64'h2);
        #2;
        inValid   = 1'b0;
        ctrlReset = 1'b0;
        #1;
        checkOutput("async reset s2 outValid", 64'(bus2.out_valid), 64'h0);
        checkOutput("async reset s2 dataOut", bus2.data_out, 64'h0);
        checkOutput("async reset s2 occupancy", 64'(bus2.occupancy), 64'h0);
        checkOutput("async reset s3 occupancy", 64'(bus3.occupancy), 64'h0);
        ctrlReset = 1'b1;
        resetModels();
        @(negedge clk);
        applyStimulus(1'b1, 64'h7, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        driveInputs(1'b0, 64'h0, 1'b1, 1'b0);
        checkOutput("post-reset s2 outValid", 64'(bus2.out_valid), 64'h1);
        checkOutput("post-reset s2 dataOut", bus2.data_out, 64'h7);
        checkModel(0);
        checkModel(1);
        advanceCycle();
        repeat (3) applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);

        // Drain a single word and look at what is left on data_out
        applyStimulus(1'b1, 64'h9, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        driveInputs(1'b0, 64'h0, 1'b1, 1'b0);
        checkOutput("drain s2 outValid", 64'(bus2.out_valid), 64'h0);
`ifdef PIPE_REGISTER_ZERO_EN
        checkOutput("drain s2 dataOut zero", bus2.data_out, 64'h0);
`endif
        checkModel(0);
        checkModel(1);
        advanceCycle();

        // Randomised traffic with varying back-pressure and occasional flush
        for (int i = 0; i < 600; i++) begin
            logic        rV;
            logic        rR;
            logic        rF;
            logic [63:0] rD;
            rV = 1'($urandom_range(0, 1));
            rD = {$urandom, $urandom};
            if (i < 200) begin
                rR = ($urandom_range(0, 3) != 0);
            end else if (i < 400) begin
                rR = ($urandom_range(0, 3) == 0);
            end else begin
                rR = 1'($urandom_range(0, 1));
            end
            rF = ($urandom_range(0, 24) == 0);
            applyStimulus(rV, rD, rR, rF);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_register.md
# pipe_register

Parametrised elastic pipeline register: a chain of `STAGES` registers, each `WIDTH` bits wide, each with its own valid bit. Stages are linked by a valid/ready handshake, so bubbles collapse and back-pressure propagates upstream. It replaces fixed-width enable registers between multdiv iteration stages and between processor pipeline stages where stall, flush and occupancy tracking are needed.

## Interface
Parameters:
- `WIDTH`, 64, data bits per stage (≥1)
- `STAGES`, 2, number of register stages (≥1)

Ports:
- `clk`  input  1  rising-edge clock
- `ctrl_reset`  input  1  asynchronous, active-low reset (0 = reset)
- `ctrl_flush`  input  1  synchronous flush of all stages
- `in_valid`  input  1  upstream word present on `data_in`
- `in_ready`  output  1  block accepts `data_in` this cycle
- `data_in`  input  `WIDTH`  write data
- `out_valid`  output  1  last stage holds a valid word
- `out_ready`  input  1  downstream accepts `data_out` this cycle
- `data_out`  output  `WIDTH`  last-stage data
- `occupancy`  output  `$clog2(STAGES+1)`  number of valid stages

## Operation
- Stage k holds `v[k]` and `d[k]`. Stage 0 is the input side; stage `STAGES-1` drives `out_valid = v[STAGES-1]` and `data_out = d[STAGES-1]`.
- Advance: `adv[STAGES-1] = out_ready | ~v[STAGES-1]`. For k < STAGES-1: `adv[k] = adv[k+1] | ~v[k]`. The ready chain is combinational across stages.
- `in_ready = adv[0] & ~ctrl_flush`.
- On a clock edge, for each stage with `adv[k]=1`:
  - k>0: `v[k] <= v[k-1]`, `d[k] <= d[k-1]`.
  - k=0: `v[0] <= in_valid & in_ready`, `d[0] <= data_in`.
  - Stages with `adv[k]=0` hold both `v` and `d`.
- Transfers:
  - Input transfer: `in_valid & in_ready`.
  - Output transfer: `out_valid & out_ready`.
  - Both may occur in the same cycle.
- `occupancy` is the registered count of valid stages: +1 on input transfer only, −1 on output transfer only, unchanged when both or neither occur. Range 0..STAGES.
- Flush:
  - When `ctrl_flush=1` at an edge, all `v[k]` and `occupancy` go to 0.
  - Any concurrent input is discarded (`in_ready` is already 0).
  - A concurrent output transfer still counts as delivered downstream.
  - Flush overrides advance.
- Reset, asserted at any time including mid-transfer: immediately and asynchronously clears all `v[k]`, all `d[k]` and `occupancy`. On the first edge after release the block accepts input normally.
- Full: `occupancy=STAGES` with `out_ready=0` gives `in_ready=0`. If `out_ready=1` while full, `in_ready=1` (pass-through, throughput maintained).
- Empty: `out_valid=0`. `out_ready` is ignored.

## Timing
- Reset values: `in_ready=1` (0 if `ctrl_flush=1`), `out_valid=0`, `data_out=0`, `occupancy=0`.
- Latency with no stalls: a word accepted at edge n appears on `out_valid`/`data_out` after edge n+STAGES−1, and is transferred at edge n+STAGES if `out_ready=1`.
- Throughput: 1 word/cycle sustained while `out_ready=1`.
- Bubble collapse: an empty stage accepts from upstream even while downstream stalls. With `out_ready=0`, a pipe fills to `STAGES` words before `in_ready` drops.
- `in_ready` depends combinationally on `out_ready` and `ctrl_flush`. No other output is combinational on inputs.

## Configuration
- Macro: `PIPE_REGISTER_ZERO_EN`.
- Defined:
  - A stage whose `v` becomes 0 on an edge (bubble shifted in, output drained with nothing behind it, or flush) also loads `d[k] <= 0`.
  - `data_out` reads 0 whenever `out_valid=0`.
- Undefined:
  - Invalid stages retain stale data; `d[k]` loads only with `adv[k]`.
  - `data_out` is don't-care while `out_valid=0`.
  - Lower power and area.
- Handshake, latency and `occupancy` are identical in both builds.

## Test plan
- Streaming: WIDTH=64, STAGES=2, `out_ready=1`, input 0x1, 0x2, 0x3 on consecutive cycles → `data_out` 0x1, 0x2, 0x3 on consecutive cycles starting 2 cycles after the first accept; `occupancy` steady at 2.
- Fill under stall: `out_ready=0`, push 0xA, 0xB → `occupancy=2`, `in_ready=0`. Then raise `out_ready` for one cycle → 0xA delivered, `in_ready=1` in the same cycle, and a new word 0xC is accepted with `occupancy` staying 2.
- Bubble collapse: STAGES=3, push 0x5, one idle cycle, push 0x6, `out_ready=0` → both words are held in stages 2 and 1, `occupancy=2`, `in_ready=1`.
- Flush: pipe full with 0xDEAD and 0xBEEF, `ctrl_flush=1` with `in_valid=1` → `in_ready=0`. Next cycle `out_valid=0` and `occupancy=0`; with the macro defined, `data_out=0`.
- Async reset mid-stream: drive `ctrl_reset=0` between edges while `occupancy=2` → `out_valid`, `data_out` and `occupancy` go to 0 without waiting for a clock edge. After release, 0x7 is accepted and delivered with normal latency.
- Macro check: compile without `PIPE_REGISTER_ZERO_EN`, drain a pipe holding 0x9 → `out_valid=0`, `data_out` may hold 0x9. Compile with the macro, same stimulus → `data_out=0`.
